dmem_responder: RTL and testbench

Responder end of the data-memory load/store interface for the multi-cycle and pipelined processor variants. It accepts one load or store request at a time over a valid/ready handshake and holds a word-addressed 64-bit storage array. After a programmable latency it returns read data, or a write acknowledge, over a second valid/ready handshake. It replaces the zero-latency data memory whenever the core's memory stage must stall on memory.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg: shared types and helpers for the data-memory responder     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned DATA_BITS  = 64;

    // Misaligned, or any byte-address bit above the word-index field set.
    function automatic logic addr_err(input logic [63:0] addr, input int unsigned addr_bits);
        logic [63:0] hi;
        hi = addr >> (addr_bits + $clog2(WORD_BYTES));
        return (addr[2:0] != 3'b000) || (hi != 64'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_array: single-port doubleword storage, sync write, comb read    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 7
) (
    input  logic                 CLK,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] index,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem_q [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[index] <= wdata;
        end
    end

    assign rdata = mem_q[index];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder: valid/ready load/store responder, fixed latency      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 7,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned           c_CNT_W    = 4;
    localparam bit                    c_SINGLE   = (LATENCY == 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_LOAD = c_CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_t               state_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic                 write_q;
    logic [63:0]          addr_q;
    logic [63:0]          wdata_q;
    logic [63:0]          rdata_q;
    logic                 err_q;

    logic                 w_in_idle;
    logic                 w_accept;
    logic                 w_enter_resp;
    logic                 w_write;
    logic [63:0]          w_addr;
    logic [63:0]          w_wdata;
    logic                 w_err;
    logic [ADDR_BITS-1:0] w_index;
    logic                 w_we;
    logic [63:0]          w_rdata;

    assign w_in_idle    = (state_q == IDLE);
    assign w_accept     = w_in_idle && req_valid;
    assign w_enter_resp = (c_SINGLE && w_accept) || ((state_q == WAIT) && (cnt_q == '0));

    // With single-cycle latency the commit edge is the accept edge, so the
    // request fields are used directly instead of the (not yet loaded) latch.
    assign w_write = w_in_idle ? req_write : write_q;
    assign w_addr  = w_in_idle ? req_addr  : addr_q;
    assign w_wdata = w_in_idle ? req_wdata : wdata_q;
    assign w_err   = addr_err(w_addr, ADDR_BITS);
    assign w_index = w_addr[ADDR_BITS+2:3];
    assign w_we    = w_enter_resp && w_write && !w_err;

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .CLK   (CLK),
        .we    (w_we),
        .index (w_index),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (w_enter_resp) begin
                rdata_q <= (w_write || w_err) ? 64'd0 : w_rdata;
                err_q   <= w_err;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= c_CNT_LOAD;
                        state_q <= c_SINGLE ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder: directed + random bench, LATENCY 2 and 1 instances |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        a_rstn = 1'b0, a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
    logic        a_resp_valid, a_resp_ready = 1'b0, a_resp_err;
    logic [63:0] a_req_addr = '0, a_req_wdata = '0, a_resp_rdata;

    logic        b_rstn = 1'b0, b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
    logic        b_resp_valid, b_resp_ready = 1'b0, b_resp_err;
    logic [63:0] b_req_addr = '0, b_req_wdata = '0, b_resp_rdata;

    dmem_responder #(.ADDR_BITS(7), .LATENCY(2)) u_dut_a (
        .CLK(CLK), .resetl(a_rstn), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(a_req_write), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    dmem_responder #(.ADDR_BITS(7), .LATENCY(1)) u_dut_b (
        .CLK(CLK), .resetl(b_rstn), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference memory: 128 doublewords addressed by byte address / 8.
    logic [63:0] a_mem [0:127];
    bit          a_vld [0:127];
    logic [63:0] b_mem [0:127];

    function automatic bit model_err(input logic [63:0] addr);
        return (addr % 64'd8 != 64'd0) || (addr >= 64'd1024);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance; entered and left at a negedge.
    task automatic a_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input int hold, input string tag);
        logic        exp_e;
        logic [63:0] exp_rd;
        logic [63:0] snap_rd;
        logic        snap_e;
        int          n;
        exp_e  = model_err(addr);
        exp_rd = (wr || exp_e) ? 64'd0 : a_mem[addr / 8];
        n = 0;
        while (!a_req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, ".req_ready"}, 64'(a_req_ready), 64'd1);
        a_req_valid = 1'b1;
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        @(posedge CLK);
        @(negedge CLK);
        a_req_valid = 1'b0;
        a_req_write = 1'($urandom);
        a_req_addr  = {$urandom, $urandom};
        a_req_wdata = {$urandom, $urandom};
        n = 1;
        while (!a_resp_valid && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'd2);
        chk({tag, ".rdata"}, a_resp_rdata, exp_rd);
        chk({tag, ".err"}, 64'(a_resp_err), 64'(exp_e));
        snap_rd = a_resp_rdata;
        snap_e  = a_resp_err;
        for (int i = 0; i < hold; i++) begin
            a_req_valid = (i == 1);
            a_req_write = 1'b1;
            a_req_addr  = 64'h40;
            a_req_wdata = {$urandom, $urandom};
            @(negedge CLK);
            chk({tag, ".hold_valid"}, 64'(a_resp_valid), 64'd1);
            chk({tag, ".hold_rdata"}, a_resp_rdata, snap_rd);
            chk({tag, ".hold_err"}, 64'(a_resp_err), 64'(snap_e));
            chk({tag, ".hold_req_ready"}, 64'(a_req_ready), 64'd0);
        end
        a_req_valid  = 1'b0;
        a_resp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        a_resp_ready = 1'b0;
        chk({tag, ".post_req_ready"}, 64'(a_req_ready), 64'd1);
        chk({tag, ".post_resp_valid"}, 64'(a_resp_valid), 64'd0);
        if (wr && !exp_e) begin
            a_mem[addr / 8] = wdata;
            a_vld[addr / 8] = 1'b1;
        end
    endtask

    initial begin : main
        logic [63:0] addr;
        logic [63:0] data;
        int          kind;
        int          idx;
        int          issued;
        int          done;
        int          last_acc;
        logic [63:0] b_exp_q [$];
        logic [63:0] b_ops_addr [0:7];
        logic [63:0] b_ops_data [0:7];

        for (int i = 0; i < 128; i++) a_vld[i] = 1'b0;

        // Reset held across a few edges, then idle checks on both instances.
        repeat (3) @(negedge CLK);
        a_rstn = 1'b1;
        b_rstn = 1'b1;
        @(negedge CLK);
        chk("rst.a.req_ready", 64'(a_req_ready), 64'd1);
        chk("rst.a.resp_valid", 64'(a_resp_valid), 64'd0);
        chk("rst.a.rdata", a_resp_rdata, 64'd0);
        chk("rst.a.err", 64'(a_resp_err), 64'd0);
        chk("rst.b.req_ready", 64'(b_req_ready), 64'd1);
        chk("rst.b.resp_valid", 64'(b_resp_valid), 64'd0);

        // Directed store/load, error cases and a stalled response.
        a_txn(1'b1, 64'h40, 64'hDEADBEEFCAFEF00D, 0, "st40");
        a_txn(1'b0, 64'h40, 64'h0, 0, "ld40");
        a_txn(1'b0, 64'h43, 64'h0, 0, "ld43");
        a_txn(1'b0, 64'h400, 64'h0, 0, "ld400");
        a_txn(1'b1, 64'h43, 64'h5555, 0, "st43");
        a_txn(1'b0, 64'h40, 64'h0, 0, "ld40b");
        a_txn(1'b0, 64'h40, 64'h0, 5, "hold40");
        a_txn(1'b0, 64'h40, 64'h0, 0, "ld40c");

        // Asynchronous reset while a store of 0x1111 to 0x8 is waiting.
        a_txn(1'b1, 64'h8, 64'h2222, 0, "st8");
        a_txn(1'b0, 64'h40, 64'h0, 0, "ld40d");
        a_req_valid = 1'b1;
        a_req_write = 1'b1;
        a_req_addr  = 64'h8;
        a_req_wdata = 64'h1111;
        @(posedge CLK);
        @(negedge CLK);
        a_req_valid = 1'b0;
        chk("wait.req_ready", 64'(a_req_ready), 64'd0);
        #2;
        a_rstn = 1'b0;
        #1;
        chk("arst.req_ready", 64'(a_req_ready), 64'd1);
        chk("arst.resp_valid", 64'(a_resp_valid), 64'd0);
        chk("arst.rdata", a_resp_rdata, 64'd0);
        chk("arst.err", 64'(a_resp_err), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        a_rstn = 1'b1;
        @(negedge CLK);
        chk("arst.idle_valid", 64'(a_resp_valid), 64'd0);
        a_txn(1'b0, 64'h8, 64'h0, 0, "ld8");

        // Random mix against the reference memory.
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 127);
            data = {$urandom, $urandom};
            if (kind == 0) begin
                addr = 64'(idx * 8 + $urandom_range(1, 7));
                a_txn(1'($urandom), addr, data, $urandom_range(0, 3), "rnd_mis");
            end else if (kind == 1) begin
                addr = ({$urandom, $urandom} & ~64'h7) | (64'h400 << $urandom_range(0, 53));
                a_txn(1'($urandom), addr, data, $urandom_range(0, 3), "rnd_oor");
            end else if (kind < 6 || !a_vld[idx]) begin
                a_txn(1'b1, 64'(idx * 8), data, $urandom_range(0, 3), "rnd_st");
            end else begin
                a_txn(1'b0, 64'(idx * 8), data, $urandom_range(0, 3), "rnd_ld");
            end
        end

        // LATENCY=1, continuous requests with resp_ready held high.
        for (int i = 0; i < 4; i++) begin
            b_ops_addr[i]     = 64'((i * 5 + 2) * 8);
            b_ops_data[i]     = {$urandom, $urandom};
            b_ops_addr[i + 4] = b_ops_addr[i];
            b_ops_data[i + 4] = 64'd0;
        end
        issued   = 0;
        done     = 0;
        last_acc = -2;
        b_resp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && done < 8; cyc++) begin
            chk("b.alternate", 64'(b_req_ready), 64'(!b_resp_valid));
            if (b_resp_valid) begin
                chk("b.rdata", b_resp_rdata, b_exp_q.pop_front());
                chk("b.err", 64'(b_resp_err), 64'd0);
                done++;
            end
            if (b_req_ready && issued < 8) begin
                if (issued > 0) chk("b.accept_gap", 64'(cyc - last_acc), 64'd2);
                last_acc    = cyc;
                b_req_valid = 1'b1;
                b_req_write = (issued < 4);
                b_req_addr  = b_ops_addr[issued];
                b_req_wdata = b_ops_data[issued];
                if (issued < 4) begin
                    b_mem[b_ops_addr[issued] / 8] = b_ops_data[issued];
                    b_exp_q.push_back(64'd0);
                end else begin
                    b_exp_q.push_back(b_mem[b_ops_addr[issued] / 8]);
                end
                issued++;
            end else if (issued == 8 && b_req_ready) begin
                b_req_valid = 1'b0;
            end
            @(negedge CLK);
        end
        chk("b.done", 64'(done), 64'd8);
        b_req_valid  = 1'b0;
        b_resp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
